// File: rtl/chip8_pkg.sv
// Shared encodings for the CHIP-8 register/memory block-transfer engine.
package chip8_pkg;

  typedef enum logic [1:0] {
    XFER_STORE = 2'd0,
    XFER_LOAD  = 2'd1,
    XFER_BCD   = 2'd2,
    XFER_RSVD  = 2'd3
  } xfer_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STORE,
    ST_LOAD,
    ST_BCD_RD,
    ST_BCD_DAB,
    ST_BCD_WR,
    ST_FIN
  } xfer_state_e;

endpackage

// File: rtl/chip8_bin2bcd.sv
// Iterative double-dabble converter. The first iteration happens on the start edge.
// valid_o flags the edge that performs the final iteration; bcd_o holds the result from the next cycle.
module chip8_bin2bcd #(
  parameter int W = 8,
  parameter int D = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic [W-1:0]   bin_i,
  output logic           busy_o,
  output logic           valid_o,
  output logic [4*D-1:0] bcd_o
);
  localparam int SW = 4*D + W;
  localparam int CW = $clog2(W+1);

  logic [SW-1:0] sh_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;

  function automatic logic [SW-1:0] dab_step(input logic [SW-1:0] s);
    logic [SW-1:0] t;
    t = s;
    for (int i = 0; i < D; i++)
      if (t[W+4*i +: 4] >= 4'd5) t[W+4*i +: 4] = t[W+4*i +: 4] + 4'd3;
    return t << 1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      sh_q   <= dab_step({{(4*D){1'b0}}, bin_i});
      cnt_q  <= CW'(W-1);
      busy_q <= (W > 1);
    end else if (busy_q) begin
      sh_q   <= dab_step(sh_q);
      cnt_q  <= cnt_q - 1'b1;
      busy_q <= (cnt_q != CW'(1));
    end
  end

  assign busy_o  = busy_q;
  assign valid_o = (busy_q && cnt_q == CW'(1)) || (start_i && W == 1);
  assign bcd_o   = sh_q[W +: 4*D];

endmodule

// File: rtl/chip8_xfer_engine.sv
// FX33/FX55/FX65 block-transfer engine between the V register file and main memory.
// Optional macro CHIP8_XFER_I_INCR_EN adds i_upd/i_new (I advanced past the block on STORE/LOAD).
module chip8_xfer_engine
  import chip8_pkg::*;
#(
  parameter int ADDR_WIDTH   = 12,
  parameter int V_ADDR_WIDTH = 4,
  parameter int V_DATA_WIDTH = 8,
  parameter int MEM_LATENCY  = 1,
  parameter int BCD_DIGITS   = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [ADDR_WIDTH-1:0]   base,
  input  logic [V_ADDR_WIDTH-1:0] x,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_WIDTH-1:0]   mem_raddr,
  input  logic [V_DATA_WIDTH-1:0] mem_q,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_waddr,
  output logic [V_DATA_WIDTH-1:0] mem_d,
  output logic [V_ADDR_WIDTH-1:0] v_raddr,
  input  logic [V_DATA_WIDTH-1:0] v_q,
  output logic                    v_we,
  output logic [V_ADDR_WIDTH-1:0] v_waddr,
`ifdef CHIP8_XFER_I_INCR_EN
  output logic                    i_upd,
  output logic [ADDR_WIDTH-1:0]   i_new,
`endif
  output logic [V_DATA_WIDTH-1:0] v_d
);
  localparam int L = MEM_LATENCY;

  xfer_state_e             state_q;
  xfer_mode_e              mode_q;
  logic [ADDR_WIDTH-1:0]   base_q, mem_raddr_q;
  logic [V_ADDR_WIDTH-1:0] x_q, rk_q, wk_q, v_raddr_q, dsel;
  logic [L:0]              vld_pipe;
  logic                    bcd_we_q, dab_go_q;
  logic                    st_we, ld_we, last_wr, bcd_busy, bcd_last;
  logic [4*BCD_DIGITS-1:0] bcd;
  logic [3:0]              digit;

  // vld_pipe[n] marks a read issued n cycles ago; its data is due at stage 1 (V) or L (memory)
  assign st_we   = (mode_q == XFER_STORE) && vld_pipe[1];
  assign ld_we   = (mode_q == XFER_LOAD)  && vld_pipe[L];
  assign last_wr = (st_we || ld_we) && (wk_q == x_q);
  assign dsel    = V_ADDR_WIDTH'(BCD_DIGITS-1) - wk_q;
  assign digit   = 4'(bcd >> {dsel, 2'b00});

  chip8_bin2bcd #(.W(V_DATA_WIDTH), .D(BCD_DIGITS)) u_bcd (
    .clk(clk), .rst(rst), .start_i(dab_go_q), .bin_i(v_q),
    .busy_o(bcd_busy), .valid_o(bcd_last), .bcd_o(bcd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= XFER_STORE;
      base_q      <= '0;
      x_q         <= '0;
      rk_q        <= '0;
      wk_q        <= '0;
      mem_raddr_q <= '0;
      v_raddr_q   <= '0;
      vld_pipe    <= '0;
      bcd_we_q    <= 1'b0;
      dab_go_q    <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[L-1:0], 1'b0};
      dab_go_q <= 1'b0;
      if (mem_we || v_we) wk_q <= wk_q + 1'b1;
      case (state_q)
        ST_IDLE, ST_FIN: begin
          state_q <= ST_IDLE;
          if (start) begin
            base_q <= base;
            x_q    <= x;
            mode_q <= xfer_mode_e'(mode);
            rk_q   <= '0;
            wk_q   <= '0;
            case (xfer_mode_e'(mode))
              XFER_STORE: begin state_q <= ST_STORE; v_raddr_q <= '0; vld_pipe[0] <= 1'b1; end
              XFER_LOAD:  begin state_q <= ST_LOAD; mem_raddr_q <= base; vld_pipe[0] <= 1'b1; end
              XFER_BCD:   begin state_q <= ST_BCD_RD; v_raddr_q <= x; end
              default:    state_q <= ST_FIN;
            endcase
          end
        end
        ST_STORE, ST_LOAD: begin
          if (rk_q != x_q) begin
            rk_q        <= rk_q + 1'b1;
            vld_pipe[0] <= 1'b1;
            if (state_q == ST_STORE) v_raddr_q <= rk_q + 1'b1;
            else mem_raddr_q <= base_q + ADDR_WIDTH'(rk_q) + ADDR_WIDTH'(1);
          end
          if (last_wr) state_q <= ST_FIN;
        end
        ST_BCD_RD: begin
          state_q  <= ST_BCD_DAB;
          dab_go_q <= 1'b1;
        end
        ST_BCD_DAB: if (bcd_last) begin
          state_q  <= ST_BCD_WR;
          bcd_we_q <= 1'b1;
        end
        ST_BCD_WR: if (wk_q == V_ADDR_WIDTH'(BCD_DIGITS-1)) begin
          state_q  <= ST_FIN;
          bcd_we_q <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state_q != ST_IDLE && state_q != ST_FIN) || bcd_busy;
  assign done      = (state_q == ST_FIN);
  assign mem_raddr = mem_raddr_q;
  assign v_raddr   = v_raddr_q;
  assign mem_we    = st_we || bcd_we_q;
  assign mem_waddr = base_q + ADDR_WIDTH'(wk_q);
  assign mem_d     = bcd_we_q ? V_DATA_WIDTH'(digit) : (st_we ? v_q : '0);
  assign v_we      = ld_we;
  assign v_waddr   = wk_q;
  assign v_d       = ld_we ? mem_q : '0;

`ifdef CHIP8_XFER_I_INCR_EN
  assign i_upd = done && (mode_q == XFER_STORE || mode_q == XFER_LOAD);
  assign i_new = base_q + ADDR_WIDTH'(x_q) + ADDR_WIDTH'(1);
`endif

endmodule

// File: tb/tb_chip8_xfer_engine.sv
// Directed bench for chip8_xfer_engine with register-file and memory models (MEM_LATENCY=2).
module tb_chip8_xfer_engine;
  localparam int AW = 12, VAW = 4, VDW = 8, LAT = 2, DIG = 3;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [AW-1:0] base = '0;
  logic [VAW-1:0] x = '0;
  logic busy, done, mem_we, v_we;
  logic [AW-1:0] mem_raddr, mem_waddr;
  logic [VDW-1:0] mem_q, mem_d, v_q, v_d, rd1;
  logic [VAW-1:0] v_raddr, v_waddr;
`ifdef CHIP8_XFER_I_INCR_EN
  logic i_upd;
  logic [AW-1:0] i_new;
  logic iu_done;
  logic [AW-1:0] inew_done;
  int iu_stray;
`endif

  logic [7:0] mem [0:4095];
  logic [7:0] vreg [0:15];
  logic pv_we = 1'b0, pm_we = 1'b0;
  logic [AW-1:0] pm_addr = '0;
  logic [VAW-1:0] pv_addr = '0;
  logic [7:0] p_d = '0;

  int n_chk = 0, n_pass = 0;
  int n_mw, n_vw, done_cyc, both;
  logic [AW-1:0] mw_addr [0:31];
  logic [7:0] mw_data [0:31], vw_data [0:31];
  logic [VAW-1:0] vw_addr [0:31];
  int mw_cyc [0:31], vw_cyc [0:31];

  chip8_xfer_engine #(.ADDR_WIDTH(AW), .V_ADDR_WIDTH(VAW), .V_DATA_WIDTH(VDW),
                      .MEM_LATENCY(LAT), .BCD_DIGITS(DIG)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .base(base), .x(x),
    .busy(busy), .done(done), .mem_raddr(mem_raddr), .mem_q(mem_q),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_d(mem_d),
    .v_raddr(v_raddr), .v_q(v_q), .v_we(v_we), .v_waddr(v_waddr),
`ifdef CHIP8_XFER_I_INCR_EN
    .i_upd(i_upd), .i_new(i_new),
`endif
    .v_d(v_d)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pm_we) mem[pm_addr] <= p_d;
    if (mem_we) mem[mem_waddr] <= mem_d;
    if (pv_we) vreg[pv_addr] <= p_d;
    if (v_we) vreg[v_waddr] <= v_d;
    v_q   <= vreg[v_raddr];
    rd1   <= mem[mem_raddr];
    mem_q <= rd1;
  end

  task automatic preset_v(input logic [VAW-1:0] a, input logic [7:0] d);
    pv_we = 1'b1; pv_addr = a; p_d = d;
    @(negedge clk);
    pv_we = 1'b0;
  endtask

  task automatic preset_m(input logic [AW-1:0] a, input logic [7:0] d);
    pm_we = 1'b1; pm_addr = a; p_d = d;
    @(negedge clk);
    pm_we = 1'b0;
  endtask

  // Start an operation at the current negedge and log strobes per cycle until done (cycle 1 = first after accept).
  task automatic run_op(input logic [1:0] m, input logic [AW-1:0] b, input logic [VAW-1:0] xi, input int budget);
    n_mw = 0; n_vw = 0; done_cyc = -1; both = 0;
`ifdef CHIP8_XFER_I_INCR_EN
    iu_done = 1'b0; inew_done = '0; iu_stray = 0;
`endif
    start = 1'b1; mode = m; base = b; x = xi;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      if (mem_we && n_mw < 32) begin
        mw_addr[n_mw] = mem_waddr; mw_data[n_mw] = mem_d; mw_cyc[n_mw] = c; n_mw++;
      end
      if (v_we && n_vw < 32) begin
        vw_addr[n_vw] = v_waddr; vw_data[n_vw] = v_d; vw_cyc[n_vw] = c; n_vw++;
      end
      if (mem_we && v_we) both++;
`ifdef CHIP8_XFER_I_INCR_EN
      if (i_upd && !done) iu_stray++;
      if (done) begin iu_done = i_upd; inew_done = i_new; end
`endif
      if (done) begin done_cyc = c; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if ({busy, done, mem_we, v_we} !== 4'b0) $display("FAIL reset_strobes: got %b want 0000", {busy, done, mem_we, v_we}); else n_pass++;
    n_chk++; if ({mem_raddr, mem_waddr, v_raddr, v_waddr} !== '0) $display("FAIL reset_addr: got %h want 0", {mem_raddr, mem_waddr, v_raddr, v_waddr}); else n_pass++;
    n_chk++; if ({mem_d, v_d} !== 16'h0) $display("FAIL reset_data: got %h want 0000", {mem_d, v_d}); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  // V[k] = (k+1)*0x11; writes land on consecutive cycles 2..x+2, done on x+3.
  task automatic test_store(input logic [AW-1:0] b, input logic [VAW-1:0] xi);
    logic [AW-1:0] ea;
    logic [7:0] ed;
    for (int k = 0; k <= int'(xi); k++) preset_v(VAW'(k), 8'((k+1) * 8'h11));
    run_op(2'd0, b, xi, 40);
    n_chk++; if (n_mw !== int'(xi) + 1) $display("FAIL store_count: got %0d want %0d", n_mw, int'(xi) + 1); else n_pass++;
    for (int k = 0; k <= int'(xi) && k < n_mw; k++) begin
      ea = b + AW'(k);
      ed = 8'((k+1) * 8'h11);
      n_chk++;
      if (mw_addr[k] !== ea || mw_data[k] !== ed || mw_cyc[k] !== k + 2)
        $display("FAIL store_wr%0d: got addr %h data %h cyc %0d want %h %h %0d", k, mw_addr[k], mw_data[k], mw_cyc[k], ea, ed, k + 2);
      else n_pass++;
    end
    n_chk++; if (done_cyc !== int'(xi) + 3) $display("FAIL store_done: got %0d want %0d", done_cyc, int'(xi) + 3); else n_pass++;
    n_chk++; if (n_vw !== 0 || both !== 0) $display("FAIL store_no_vwe: got %0d/%0d want 0/0", n_vw, both); else n_pass++;
  endtask

  task automatic test_load();
    for (int k = 0; k < 16; k++) preset_m(AW'(12'h200 + k), 8'(k * 3));
    run_op(2'd1, 12'h200, 4'hF, 40);
    n_chk++; if (n_vw !== 16) $display("FAIL load_count: got %0d want 16", n_vw); else n_pass++;
    for (int k = 0; k < 16 && k < n_vw; k++) begin
      n_chk++;
      if (vw_addr[k] !== VAW'(k) || vw_data[k] !== 8'(k * 3) || vw_cyc[k] !== k + 3)
        $display("FAIL load_wr%0d: got idx %0d data %h cyc %0d want %0d %h %0d", k, vw_addr[k], vw_data[k], vw_cyc[k], k, 8'(k * 3), k + 3);
      else n_pass++;
    end
    n_chk++; if (done_cyc !== 19) $display("FAIL load_done: got %0d want 19", done_cyc); else n_pass++;
    n_chk++; if (n_mw !== 0) $display("FAIL load_no_mwe: got %0d want 0", n_mw); else n_pass++;
    n_chk++; if (vreg[15] !== 8'd45 || vreg[7] !== 8'd21) $display("FAIL load_regs: got %h %h want 2d 15", vreg[15], vreg[7]); else n_pass++;
  endtask

  // Digits written MSD first at cycles 10..12, done at 13.
  task automatic test_bcd(input logic [VAW-1:0] xi, input logic [7:0] val, input logic [AW-1:0] b,
                          input logic [3:0] d2, input logic [3:0] d1, input logic [3:0] d0);
    logic [3:0] dg [0:2];
    dg[0] = d2; dg[1] = d1; dg[2] = d0;
    preset_v(xi, val);
    run_op(2'd2, b, xi, 40);
    n_chk++; if (n_mw !== 3) $display("FAIL bcd_count_%h: got %0d want 3", val, n_mw); else n_pass++;
    for (int j = 0; j < 3 && j < n_mw; j++) begin
      n_chk++;
      if (mw_addr[j] !== b + AW'(j) || mw_data[j] !== {4'h0, dg[j]} || mw_cyc[j] !== 10 + j)
        $display("FAIL bcd_%h_wr%0d: got addr %h data %h cyc %0d want %h %h %0d", val, j, mw_addr[j], mw_data[j], mw_cyc[j], b + AW'(j), {4'h0, dg[j]}, 10 + j);
      else n_pass++;
    end
    n_chk++; if (done_cyc !== 13) $display("FAIL bcd_done_%h: got %0d want 13", val, done_cyc); else n_pass++;
    n_chk++; if (n_vw !== 0) $display("FAIL bcd_no_vwe_%h: got %0d want 0", val, n_vw); else n_pass++;
  endtask

  // Reserved op, then a new STORE accepted in its done cycle.
  task automatic test_back_to_back();
    preset_v(4'd0, 8'h5C);
    run_op(2'd3, 12'h123, 4'h2, 10);
    n_chk++; if (done_cyc !== 1 || n_mw + n_vw !== 0) $display("FAIL rsvd: got done %0d strobes %0d want 1 0", done_cyc, n_mw + n_vw); else n_pass++;
    run_op(2'd0, 12'h500, 4'h0, 10);
    n_chk++; if (n_mw !== 1 || mw_addr[0] !== 12'h500 || mw_data[0] !== 8'h5C || mw_cyc[0] !== 2)
      $display("FAIL b2b_wr: got n %0d addr %h data %h cyc %0d want 1 500 5c 2", n_mw, mw_addr[0], mw_data[0], mw_cyc[0]);
    else n_pass++;
    n_chk++; if (done_cyc !== 3) $display("FAIL b2b_done: got %0d want 3", done_cyc); else n_pass++;
  endtask

  // Relies on mem[0x200+k] from test_load. A start while busy must be dropped; rst kills the transfer.
  task automatic test_abort();
    int vw, mw, dn, late;
    vw = 0; mw = 0; dn = 0; late = 0;
    start = 1'b1; mode = 2'd1; base = 12'h200; x = 4'hF;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      if (v_we) vw++;
      if (mem_we) mw++;
      if (done) dn++;
      if (c == 2) begin start = 1'b1; mode = 2'd0; x = 4'h0; end else start = 1'b0;
      if (c == 5) rst = 1'b1;
      @(negedge clk);
    end
    n_chk++; if (vw !== 3 || mw !== 0 || dn !== 0) $display("FAIL abort_pre: got vwe %0d mwe %0d done %0d want 3 0 0", vw, mw, dn); else n_pass++;
    n_chk++; if ({busy, done, v_we, mem_we} !== 4'b0) $display("FAIL abort_rst: got %b want 0000", {busy, done, v_we, mem_we}); else n_pass++;
    rst = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (v_we || mem_we || done || busy) late++;
      @(negedge clk);
    end
    n_chk++; if (late !== 0) $display("FAIL abort_post: got %0d active cycles want 0", late); else n_pass++;
  endtask

`ifdef CHIP8_XFER_I_INCR_EN
  task automatic test_i_incr();
    for (int k = 0; k <= 2; k++) preset_v(VAW'(k), 8'(k + 1));
    run_op(2'd0, 12'h300, 4'h2, 40);
    n_chk++; if (iu_done !== 1'b1 || inew_done !== 12'h303 || iu_stray !== 0)
      $display("FAIL i_incr_store: got upd %b new %h stray %0d want 1 303 0", iu_done, inew_done, iu_stray);
    else n_pass++;
    preset_v(4'd5, 8'hFE);
    run_op(2'd2, 12'h400, 4'd5, 40);
    n_chk++; if (iu_done !== 1'b0 || iu_stray !== 0 || done_cyc !== 13)
      $display("FAIL i_incr_bcd: got upd %b stray %0d done %0d want 0 0 13", iu_done, iu_stray, done_cyc);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_store(12'h300, 4'd3);
    test_load();
    test_bcd(4'd5, 8'hFE, 12'h400, 4'd2, 4'd5, 4'd4);
    test_bcd(4'd9, 8'hFF, 12'h410, 4'd2, 4'd5, 4'd5);
    test_bcd(4'd0, 8'h00, 12'h420, 4'd0, 4'd0, 4'd0);
    test_bcd(4'd3, 8'h63, 12'hFFE, 4'd0, 4'd9, 4'd9);
    test_store(12'hFFF, 4'd1);
    test_store(12'h7A0, 4'd0);
    test_back_to_back();
`ifdef CHIP8_XFER_I_INCR_EN
    test_i_incr();
`endif
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
